// File: rtl/sram_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sram_bank : single-port R/W bank with bit-masked writes plus a          |
// |             read-only video port; optional power-up clear selected by   |
// |             the macro SRAM_BANK_INIT_EN.                                |
// | Revision  : 1.0                                                        |
// +------------------------------------------------------------------------+
module sram_bank #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              cs_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] wmask,
   output logic [DATA_W-1:0] dout,
   output logic              ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

`ifdef SRAM_BANK_INIT_EN
   localparam state_t c_reset_state = ST_INIT;
   localparam logic [ADDR_W-1:0] c_last_addr = '1;
`else
   localparam state_t c_reset_state = ST_IDLE;
`endif

   state_t            r_state;
   logic              r_ready;
   logic [DATA_W-1:0] r_dout;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_a_rd;
   logic              w_a_wr;
   logic              w_b_rd;
   logic [DATA_W-1:0] w_a_wdata;

   assign w_a_rd    = r_ready & ~cs_b &  we_b;
   assign w_a_wr    = r_ready & ~cs_b & ~we_b;
   assign w_b_rd    = r_ready & rd_en;
   assign w_a_wdata = (din & wmask) | (r_mem[addr] & ~wmask);

`ifdef SRAM_BANK_INIT_EN
   logic [ADDR_W-1:0] r_clr_cnt;
   logic              w_clr_we;

   assign w_clr_we = (r_state == ST_INIT);

   // Storage has no reset; the INIT sweep is the only way contents get zeroed.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_a_wr) begin
         r_mem[addr] <= w_a_wdata;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (w_a_wr) begin
         r_mem[addr] <= w_a_wdata;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state    <= c_reset_state;
         r_ready    <= 1'b0;
         r_dout     <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
`ifdef SRAM_BANK_INIT_EN
         r_clr_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            ST_INIT: begin
`ifdef SRAM_BANK_INIT_EN
               if (r_clr_cnt == c_last_addr) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end
               r_clr_cnt <= r_clr_cnt + 1'b1;
`else
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
`endif
            end
            default: r_ready <= 1'b1;
         endcase

         // Reads sample the array before this edge's write lands, so a
         // colliding port B read returns the old word.
         if (w_a_rd) begin
            r_dout <= r_mem[addr];
         end
         r_rd_valid <= w_b_rd;
         if (w_b_rd) begin
            r_rd_data <= r_mem[rd_addr];
         end
      end
   end

   assign dout     = r_dout;
   assign ready    = r_ready;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_sram_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sram_bank : randomized bench for sram_bank against a word-level     |
// |                memory model with per-bit known tracking.               |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module tb_sram_bank;

   localparam int DATA_W = 4;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
`ifdef SRAM_BANK_INIT_EN
   localparam int READY_LAT  = 1024;
   localparam bit INIT_BUILD = 1'b1;
`else
   localparam int READY_LAT  = 1;
   localparam bit INIT_BUILD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_b = 1'b0;
   logic              cs_b = 1'b1;
   logic              we_b = 1'b1;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] din = '0;
   logic [DATA_W-1:0] wmask = '0;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [DATA_W-1:0] dout;
   logic              ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .cs_b     (cs_b),
      .we_b     (we_b),
      .addr     (addr),
      .din      (din),
      .wmask    (wmask),
      .dout     (dout),
      .ready    (ready),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   // Reference model: memory words plus a mask of bits whose value is known.
   logic [DATA_W-1:0] m_mem   [DEPTH];
   logic [DATA_W-1:0] m_known [DEPTH];
   logic [DATA_W-1:0] e_dout, e_dout_k, e_rd, e_rd_k;
   logic              e_valid, e_ready;
   int                since_rel;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]   = '0;
         m_known[i] = '0;
      end
      e_dout = '0; e_dout_k = '1; e_rd = '0; e_rd_k = '1;
      e_valid = 1'b0; e_ready = 1'b0; since_rel = 0;
   end

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         e_dout = '0; e_dout_k = '1; e_rd = '0; e_rd_k = '1;
         e_valid = 1'b0; e_ready = 1'b0; since_rel = 0;
      end else begin
         e_valid = e_ready & rd_en;
         if (e_ready) begin
            if (rd_en) begin
               e_rd   = m_mem[rd_addr];
               e_rd_k = m_known[rd_addr];
            end
            if (!cs_b && we_b) begin
               e_dout   = m_mem[addr];
               e_dout_k = m_known[addr];
            end
            if (!cs_b && !we_b) begin
               m_mem[addr]   = (din & wmask) | (m_mem[addr] & ~wmask);
               m_known[addr] = m_known[addr] | wmask;
            end
         end
         if (since_rel < READY_LAT) since_rel++;
         if (!e_ready && since_rel == READY_LAT) begin
            e_ready = 1'b1;
            if (INIT_BUILD) begin
               for (int i = 0; i < DEPTH; i++) begin
                  m_mem[i]   = '0;
                  m_known[i] = '1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("ready",    32'(ready),    32'(e_ready));
      check("rd_valid", 32'(rd_valid), 32'(e_valid));
      check("dout",     32'(dout & e_dout_k),  32'(e_dout & e_dout_k));
      check("rd_data",  32'(rd_data & e_rd_k), 32'(e_rd & e_rd_k));
   end

   task automatic step(input logic c, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m,
                       input logic r, input logic [ADDR_W-1:0] ra);
      cs_b = c; we_b = w; addr = a; din = d; wmask = m; rd_en = r; rd_addr = ra;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [DATA_W-1:0] m);
      step(1'b0, 1'b0, a, d, m, 1'b0, '0);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a);
      step(1'b0, 1'b1, a, '0, '0, 1'b0, '0);
   endtask

   function automatic logic [ADDR_W-1:0] pick_addr();
      logic [ADDR_W-1:0] a;
      if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, DEPTH - 1));
      else                           a = ADDR_W'($urandom_range(0, 15));
      if (a == 10'h155) a = 10'h156;
      return a;
   endfunction

   task automatic rand_step();
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), pick_addr(),
           DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)), pick_addr());
   endtask

   task automatic wait_ready(input int exp_lat);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         idle();
         n++;
      end
      check("ready_latency", 32'(n), 32'(exp_lat));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_dout",     32'(dout),     32'h0);
      check("rst_rd_data",  32'(rd_data),  32'h0);
      check("rst_rd_valid", 32'(rd_valid), 32'h0);
      check("rst_ready",    32'(ready),    32'h0);

      #2 rst_b = 1'b1;
      wait_ready(READY_LAT);

`ifdef SRAM_BANK_INIT_EN
      rd(10'h2AB);
      check("init_zero_2ab", 32'(dout), 32'h0);
      rd(10'h3FF);
      check("init_zero_3ff", 32'(dout), 32'h0);
`endif

      wr(10'h155, 4'hA, 4'hF);
      rd(10'h155);
      check("wr_rd_155", 32'(dout), 32'hA);

      wr(10'h3FF, 4'hA, 4'hF);
      wr(10'h3FF, 4'h5, 4'h3);
      rd(10'h3FF);
      check("masked_3ff", 32'(dout), 32'h9);

      wr(10'h020, 4'h2, 4'hF);
      step(1'b0, 1'b0, 10'h020, 4'h7, 4'hF, 1'b1, 10'h020);
      check("collide_old",   32'(rd_data),  32'h2);
      check("collide_valid", 32'(rd_valid), 32'h1);
      step(1'b1, 1'b1, '0, '0, '0, 1'b1, 10'h020);
      check("collide_new", 32'(rd_data), 32'h7);
      idle();
      check("valid_drop", 32'(rd_valid), 32'h0);

      wr(10'h001, 4'hC, 4'hF);
      rd(10'h001);
      check("wr_rd_001", 32'(dout), 32'hC);
      step(1'b1, 1'b0, 10'h001, 4'h3, 4'hF, 1'b0, '0);
      rd(10'h001);
      check("cs_blocks_wr", 32'(dout), 32'hC);

      repeat (600) rand_step();

      // Reset, then interrupt the restart after 500 cycles.
      #2 rst_b = 1'b0;
      idle();
      check("rst2_ready", 32'(ready), 32'h0);
      #2 rst_b = 1'b1;
      repeat (500) rand_step();
      check("mid_ready", 32'(ready), 32'(READY_LAT <= 500));
      #2 rst_b = 1'b0;
      idle();
      check("mid_rst_ready", 32'(ready), 32'h0);
      check("mid_rst_dout",  32'(dout),  32'h0);
      #2 rst_b = 1'b1;
      wait_ready(READY_LAT);
      rd(10'h155);
      check("post_rst_155", 32'(dout), INIT_BUILD ? 32'h0 : 32'hA);

      repeat (300) rand_step();
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
